// File: rtl/lif_neuron_core.sv
// Leaky integrate-and-fire neuron: leak by right shift, programmable threshold, refractory period.
// Optional wrapping spike counter is built only when LIF_SPIKE_COUNT_EN is defined.
module lif_neuron_core #(
    parameter int unsigned DW           = 8,
    parameter int unsigned LEAK_SHIFT   = 3,
    parameter int unsigned REFRAC_STEPS = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    input  logic [DW-1:0] current_in,
    input  logic [DW-1:0] threshold,
    output logic [DW-1:0] membrane,
    output logic          spike,
    output logic          refractory,
    output logic [7:0]    spike_count
);
    localparam int unsigned   CW          = 4;
    localparam int unsigned   SW          = DW + 1;
    localparam logic [CW-1:0] REFRAC_INIT = CW'(REFRAC_STEPS);
    localparam logic [DW-1:0] V_MAX       = {DW{1'b1}};

    typedef enum logic {
        ST_INTEGRATE  = 1'b0,
        ST_REFRACTORY = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] mem_q, mem_d;
    logic          spike_q, spike_d;
    logic          refrac_q, refrac_d;
    logic [SW-1:0] v_sum;
    logic [DW-1:0] v_sat;

    // Leaky integration in DW+1 bits; the leak never exceeds the membrane so no underflow.
    always_comb begin
        v_sum = {1'b0, mem_q} - {1'b0, DW'(mem_q >> LEAK_SHIFT)} + {1'b0, current_in};
        v_sat = v_sum[DW] ? V_MAX : v_sum[DW-1:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_d   = mem_q;
        spike_d = 1'b0;
        if (step) begin
            case (state_q)
                ST_INTEGRATE: begin
                    if (v_sat >= threshold) begin
                        spike_d = 1'b1;
                        mem_d   = '0;
                        if (REFRAC_STEPS != 0) begin
                            cnt_d   = REFRAC_INIT;
                            state_d = ST_REFRACTORY;
                        end
                    end else begin
                        mem_d = v_sat;
                    end
                end
                ST_REFRACTORY: begin
                    mem_d = '0;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = ST_INTEGRATE;
                    end
                end
                default: begin
                    state_d = ST_INTEGRATE;
                    cnt_d   = '0;
                end
            endcase
        end
        refrac_d = (cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_INTEGRATE;
            cnt_q    <= '0;
            mem_q    <= '0;
            spike_q  <= 1'b0;
            refrac_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mem_q    <= mem_d;
            spike_q  <= spike_d;
            refrac_q <= refrac_d;
        end
    end

    assign membrane   = mem_q;
    assign spike      = spike_q;
    assign refractory = refrac_q;

`ifdef LIF_SPIKE_COUNT_EN
    logic [7:0] count_q;

    // Counts on the same edge that raises spike; wraps naturally at 8 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (spike_d) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign spike_count = count_q;
`else
    assign spike_count = 8'd0;
`endif

endmodule
